// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption core: one round per clock over a single
// registered 128-bit state, with combinational SubBytes/ShiftRows/MixColumns.
// State bytes are FIPS-197 column-major: byte i = bits [8i +: 8] of a [0:127] vector.

// S-box for one byte: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sub_bytes (
    input  logic [7:0] data,
    output logic [7:0] sub
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the inverse for a != 0 and maps 0 to 0, as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a4, a8, a16, a32, a64, a128;
        a2   = gf_mul(a, a);
        a4   = gf_mul(a2, a2);
        a8   = gf_mul(a4, a4);
        a16  = gf_mul(a8, a8);
        a32  = gf_mul(a16, a16);
        a64  = gf_mul(a32, a32);
        a128 = gf_mul(a64, a64);
        return gf_mul(gf_mul(gf_mul(a2, a4), gf_mul(a8, a16)),
                      gf_mul(gf_mul(a32, a64), a128));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Purely combinational lookup
    always_comb begin
        sub = affine(gf_inv(data));
    end

endmodule

module aes_round_engine #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              Run,
    input  logic [0:127]                      Plaintext,
    input  logic [0:128*(NUM_ROUNDS+1)-1]     KeySchedule,
    output logic [0:127]                      Ciphertext,
    output logic                              Ready,
    output logic                              Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    // Last full (MixColumns) round; the FINAL round follows it
    localparam logic [3:0] LAST_MID = 4'(NUM_ROUNDS - 1);

    fsm_t         fsm_q;
    fsm_t         fsm_d;
    logic [3:0]   round_q;
    logic [0:127] state_q;
    logic [0:127] ct_q;

    logic [0:127] sub_bytes;
    logic [0:127] rk_first;
    logic [0:127] rk_cur;
    logic [0:127] rk_last;
    logic [0:127] round_out;
    logic [0:127] final_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r (byte 4c+r) rotates left by r columns
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c + r) +: 8] = s[8*(4*((c + r) % 4) + r) +: 8];
            end
        end
        return o;
    endfunction

    // Each column multiplied by [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]
    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)     +: 8];
            a1 = s[8*(4*c + 1) +: 8];
            a2 = s[8*(4*c + 2) +: 8];
            a3 = s[8*(4*c + 3) +: 8];
            o[8*(4*c)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[8*(4*c + 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[8*(4*c + 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[8*(4*c + 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Sixteen parallel S-boxes over the current state
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sub_bytes u_sbox (
            .data (state_q[8*i +: 8]),
            .sub  (sub_bytes[8*i +: 8])
        );
    end

    // Round key selection and combinational round results
    always_comb begin
        rk_first  = KeySchedule[0 +: 128];
        rk_cur    = KeySchedule[{round_q, 7'd0} +: 128];
        rk_last   = KeySchedule[128*NUM_ROUNDS +: 128];
        round_out = mix_columns(shift_rows(sub_bytes)) ^ rk_cur;
        final_out = shift_rows(sub_bytes) ^ rk_last;
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    // Next-state logic and status outputs; DONE waits for Run to drop before rearming
    always_comb begin
        fsm_d = fsm_q;
        Ready = 1'b0;
        Busy  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (Run) fsm_d = ROUND;
            end
            ROUND: begin
                Busy = 1'b1;
                if (round_q == LAST_MID) fsm_d = FINAL;
            end
            FINAL: begin
                Busy  = 1'b1;
                fsm_d = DONE;
            end
            DONE: begin
                Ready = 1'b1;
                if (!Run) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Round counter, state and ciphertext registers; reset discards any partial result
    always_ff @(posedge Clk) begin
        if (Reset) begin
            round_q <= 4'd0;
            state_q <= '0;
            ct_q    <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (Run) begin
                        state_q <= Plaintext ^ rk_first;
                        round_q <= 4'd1;
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    round_q <= round_q + 4'd1;
                end
                FINAL: begin
                    state_q <= final_out;
                    ct_q    <= final_out;
                end
                default: begin
                end
            endcase
        end
    end

    assign Ciphertext = ct_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine against FIPS-197 vectors.
// The key schedule is produced by a local KeyExpansion function standing in for the upstream block.
module tb_aes_round_engine;

    localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          Clk;
    logic          Reset;
    logic          Run;
    logic [0:127]  Plaintext;
    logic [0:1407] KeySchedule;
    logic [0:127]  Ciphertext;
    logic          Ready;
    logic          Busy;

    logic [0:1407] ks_b;
    logic [0:1407] ks_c;
    int            checks;
    int            passes;

    aes_round_engine #(.NUM_ROUNDS(10)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run         (Run),
        .Plaintext   (Plaintext),
        .KeySchedule (KeySchedule),
        .Ciphertext  (Ciphertext),
        .Ready       (Ready),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1);
    end

    // Carry-less product then reduction by 0x11b
    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    // Inverse by exhaustive search, then bitwise affine transform
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++) if (tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [0:1407] key_expand(input logic [0:127] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Advance until Ready (bounded); n is the number of edges taken, 40 on timeout
    task automatic wait_ready(output int n);
        n = 0;
        while (Ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Run   = 1'b1;
        tick();
        tick();
        checks++; if (Ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", Ready); else passes++;
        checks++; if (Busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", Busy); else passes++;
        checks++; if (Ciphertext !== 128'h0) $display("FAIL rst_ct: got %h expected 0", Ciphertext); else passes++;
        Reset = 1'b0;
        Run   = 1'b0;
        tick();
        checks++; if (Busy !== 1'b0) $display("FAIL rst_idle_busy: got %b expected 0", Busy); else passes++;
    endtask

    task automatic test_fips_b();
        logic early;
        KeySchedule = ks_b;
        Plaintext   = PT_B;
        Run         = 1'b1;
        tick();
        checks++; if (Busy !== 1'b1) $display("FAIL b_busy_e0: got %b expected 1", Busy); else passes++;
        checks++; if (Ready !== 1'b0) $display("FAIL b_ready_e0: got %b expected 0", Ready); else passes++;
        early = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n < 10 && Ready !== 1'b0) early = 1'b1;
        end
        checks++; if (early !== 1'b0) $display("FAIL b_early_ready: got %b expected 0", early); else passes++;
        checks++; if (Ready !== 1'b1) $display("FAIL b_ready_e10: got %b expected 1", Ready); else passes++;
        checks++; if (Busy !== 1'b0) $display("FAIL b_busy_done: got %b expected 0", Busy); else passes++;
        checks++; if (Ciphertext !== CT_B) $display("FAIL b_ct: got %h expected %h", Ciphertext, CT_B); else passes++;
    endtask

    task automatic test_run_held();
        int bad_ready;
        int bad_busy;
        int bad_ct;
        bad_ready = 0;
        bad_busy  = 0;
        bad_ct    = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (Ready !== 1'b1) bad_ready++;
            if (Busy !== 1'b0) bad_busy++;
            if (Ciphertext !== CT_B) bad_ct++;
        end
        checks++; if (bad_ready != 0) $display("FAIL held_ready: got %0d bad cycles expected 0", bad_ready); else passes++;
        checks++; if (bad_busy != 0) $display("FAIL held_busy: got %0d bad cycles expected 0", bad_busy); else passes++;
        checks++; if (bad_ct != 0) $display("FAIL held_ct: got %0d bad cycles expected 0", bad_ct); else passes++;
        Run = 1'b0;
        tick();
        checks++; if (Ready !== 1'b0) $display("FAIL held_idle_ready: got %b expected 0", Ready); else passes++;
        checks++; if (Ciphertext !== CT_B) $display("FAIL idle_ct_hold: got %h expected %h", Ciphertext, CT_B); else passes++;
        tick();
        checks++; if (Busy !== 1'b0) $display("FAIL idle_no_restart: got %b expected 0", Busy); else passes++;
    endtask

    task automatic test_fips_c1();
        int n;
        KeySchedule = ks_c;
        Plaintext   = PT_C;
        Run         = 1'b1;
        tick();
        Run = 1'b0;
        wait_ready(n);
        checks++; if (n != 10) $display("FAIL c1_latency: got %0d expected 10", n); else passes++;
        checks++; if (Ciphertext !== CT_C) $display("FAIL c1_ct: got %h expected %h", Ciphertext, CT_C); else passes++;
        tick();
        checks++; if (Ready !== 1'b0) $display("FAIL c1_idle_ready: got %b expected 0", Ready); else passes++;
    endtask

    task automatic test_reset_mid();
        int n;
        KeySchedule = ks_b;
        Plaintext   = PT_B;
        Run         = 1'b1;
        tick();
        Run = 1'b0;
        repeat (4) tick();
        Reset = 1'b1;
        tick();
        checks++; if (Ready !== 1'b0) $display("FAIL mid_rst_ready: got %b expected 0", Ready); else passes++;
        checks++; if (Busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", Busy); else passes++;
        checks++; if (Ciphertext !== 128'h0) $display("FAIL mid_rst_ct: got %h expected 0", Ciphertext); else passes++;
        Reset = 1'b0;
        tick();
        checks++; if (Busy !== 1'b0) $display("FAIL mid_rst_no_resume: got %b expected 0", Busy); else passes++;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        wait_ready(n);
        checks++; if (n != 10) $display("FAIL mid_rerun_latency: got %0d expected 10", n); else passes++;
        checks++; if (Ciphertext !== CT_B) $display("FAIL mid_rerun_ct: got %h expected %h", Ciphertext, CT_B); else passes++;
        tick();
    endtask

    task automatic test_pt_change();
        int n;
        KeySchedule = ks_c;
        Plaintext   = PT_C;
        Run         = 1'b1;
        tick();
        Run = 1'b0;
        tick();
        tick();
        Plaintext = 128'hdeadbeef0123456789abcdeffedcba98;
        tick();
        wait_ready(n);
        checks++; if (n != 7) $display("FAIL ptchg_latency: got %0d expected 7", n); else passes++;
        checks++; if (Ciphertext !== CT_C) $display("FAIL ptchg_ct: got %h expected %h", Ciphertext, CT_C); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        KeySchedule = ks_b;
        Plaintext   = PT_B;
        Run         = 1'b1;
        tick();
        wait_ready(n);
        checks++; if (n != 10) $display("FAIL b2b_first_latency: got %0d expected 10", n); else passes++;
        checks++; if (Ciphertext !== CT_B) $display("FAIL b2b_first_ct: got %h expected %h", Ciphertext, CT_B); else passes++;
        Run = 1'b0;
        tick();
        checks++; if (Ready !== 1'b0) $display("FAIL b2b_gap_ready: got %b expected 0", Ready); else passes++;
        KeySchedule = ks_c;
        Plaintext   = PT_C;
        Run         = 1'b1;
        tick();
        checks++; if (Busy !== 1'b1) $display("FAIL b2b_second_start: got %b expected 1", Busy); else passes++;
        Run = 1'b0;
        wait_ready(n);
        checks++; if (n != 10) $display("FAIL b2b_second_latency: got %0d expected 10", n); else passes++;
        checks++; if (Ciphertext !== CT_C) $display("FAIL b2b_second_ct: got %h expected %h", Ciphertext, CT_C); else passes++;
        tick();
    endtask

    initial begin
        Clk         = 1'b0;
        Reset       = 1'b1;
        Run         = 1'b0;
        Plaintext   = '0;
        KeySchedule = '0;
        checks      = 0;
        passes      = 0;
        ks_b        = key_expand(KEY_B);
        ks_c        = key_expand(KEY_C);

        test_reset();
        test_fips_b();
        test_run_held();
        test_fips_c1();
        test_reset_mid();
        test_pt_change();
        test_back_to_back();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
